axis_cweight_stage: RTL and testbench

Multi-channel complex beam-weighting stage for the ADC datapath. Each of NUM_CH independent AXI4-Stream channels carries SAMPLES complex samples per beat. Every sample is multiplied by a per-channel complex weight. The block adds the full valid/ready backpressure, TLAST propagation and packet-aligned weight updates that the earlier pass-through adder stage lacked. It sits between the ADC capture streams and the beam-summing/DMA stages.

---
 rtl/cweight_pkg.sv | 49 ++++
 rtl/cmul_pipe.sv | 55 +++++
 rtl/axis_cweight_stage.sv | 106 ++++++++++
 tb/tb_axis_cweight_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cweight_pkg.sv
// Shared widths, types, reset weight and output scaling for axis_cweight_stage.
// CWEIGHT_ROUND_SAT_EN selects round_sat over trunc_wrap in the scaling stage.
package cweight_pkg;

  localparam int SAMPLE_WIDTH = 8;
  localparam int WEIGHT_WIDTH = 16;
  localparam int SAMPLES_DEF  = 8;
  localparam int DATA_W       = 2 * SAMPLE_WIDTH * SAMPLES_DEF;
  localparam int PROD_W       = SAMPLE_WIDTH + WEIGHT_WIDTH + 1;
  localparam int SHIFT        = WEIGHT_WIDTH - 1;

  typedef logic signed [SAMPLE_WIDTH-1:0]              sample_t;
  typedef logic signed [WEIGHT_WIDTH-1:0]              weight_t;
  typedef logic signed [SAMPLE_WIDTH+WEIGHT_WIDTH-1:0] prod_t;
  typedef logic signed [PROD_W-1:0]                    full_t;
  typedef logic signed [PROD_W:0]                      rnd_t;

  typedef struct packed {
    weight_t re;
    weight_t im;
  } cweight_t;

  localparam weight_t  W_UNITY = weight_t'(2 ** (WEIGHT_WIDTH - 1) - 1);
  localparam cweight_t W_RESET = '{re: W_UNITY, im: weight_t'(0)};

  localparam rnd_t ROUND_HALF = rnd_t'(2 ** (SHIFT - 1));
  localparam rnd_t SAT_MAX    = rnd_t'(2 ** (SAMPLE_WIDTH - 1) - 1);
  localparam rnd_t SAT_MIN    = rnd_t'(-(2 ** (SAMPLE_WIDTH - 1)));

  // Round half up, then clamp to the sample range.
  function automatic sample_t round_sat(input full_t full);
    rnd_t t;
    t = ($signed({full[PROD_W-1], full}) + ROUND_HALF) >>> SHIFT;
    if (t > SAT_MAX) return sample_t'(SAT_MAX);
    if (t < SAT_MIN) return sample_t'(SAT_MIN);
    return sample_t'(t);
  endfunction

  // Floor, then keep the low sample bits (two's-complement wrap).
  function automatic sample_t trunc_wrap(input full_t full);
    return sample_t'(full >>> SHIFT);
  endfunction

  // Bit offset of sample k inside one channel's TDATA.
  function automatic int samp_lsb(input int k);
    return k * 2 * SAMPLE_WIDTH;
  endfunction

endpackage

// File: rtl/cmul_pipe.sv
// Two-stage complex multiply of one sample by one weight, with per-stage advance.
// Scaling mode follows CWEIGHT_ROUND_SAT_EN (round/saturate) or trunc/wrap.
module cmul_pipe
  import cweight_pkg::*;
(
  input  logic    clock,
  input  logic    adv1,
  input  logic    adv2,
  input  sample_t a_re,
  input  sample_t a_im,
  input  weight_t w_re,
  input  weight_t w_im,
  output sample_t y_re,
  output sample_t y_im
);

  prod_t   rr_p1, ii_p1, ri_p1, ir_p1;
  full_t   sum_re, sum_im;
  sample_t sc_re, sc_im;
  sample_t re_p2, im_p2;

  // Stage 1: partial products
  always_ff @(posedge clock) begin
    if (adv1) begin
      rr_p1 <= prod_t'(a_re) * prod_t'(w_re);
      ii_p1 <= prod_t'(a_im) * prod_t'(w_im);
      ri_p1 <= prod_t'(a_re) * prod_t'(w_im);
      ir_p1 <= prod_t'(a_im) * prod_t'(w_re);
    end
  end

  always_comb begin
    sum_re = full_t'(rr_p1) - full_t'(ii_p1);
    sum_im = full_t'(ri_p1) + full_t'(ir_p1);
`ifdef CWEIGHT_ROUND_SAT_EN
    sc_re  = round_sat(sum_re);
    sc_im  = round_sat(sum_im);
`else
    sc_re  = trunc_wrap(sum_re);
    sc_im  = trunc_wrap(sum_im);
`endif
  end

  // Stage 2: scaled output register
  always_ff @(posedge clock) begin
    if (adv2) begin
      re_p2 <= sc_re;
      im_p2 <= sc_im;
    end
  end

  assign y_re = re_p2;
  assign y_im = im_p2;

endmodule

// File: rtl/axis_cweight_stage.sv
// Multi-channel AXI4-Stream complex beam-weighting stage with packet-aligned weight updates.
// Define CWEIGHT_ROUND_SAT_EN for round-half-up/saturate output; default truncates and wraps.
module axis_cweight_stage
  import cweight_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int SAMPLES = SAMPLES_DEF
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic [NUM_CH*2*SAMPLE_WIDTH*SAMPLES-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]                        s_axis_tvalid,
  input  logic [NUM_CH-1:0]                        s_axis_tlast,
  output logic [NUM_CH-1:0]                        s_axis_tready,
  output logic [NUM_CH*2*SAMPLE_WIDTH*SAMPLES-1:0] m_axis_tdata,
  output logic [NUM_CH-1:0]                        m_axis_tvalid,
  output logic [NUM_CH-1:0]                        m_axis_tlast,
  input  logic [NUM_CH-1:0]                        m_axis_tready,
  input  logic [NUM_CH*WEIGHT_WIDTH-1:0]           weight_re,
  input  logic [NUM_CH*WEIGHT_WIDTH-1:0]           weight_im,
  input  logic                                     weight_update,
  output logic [NUM_CH-1:0]                        weight_pending
);

  localparam int CH_W = 2 * SAMPLE_WIDTH * SAMPLES;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic     vld_p1, vld_p2, last_p1, last_p2;
    logic     adv1, adv2, acc, in_pkt, pending, first_apply;
    cweight_t w_act, w_shd, w_use;

    assign adv2          = !vld_p2 | m_axis_tready[c];
    assign adv1          = !vld_p1 | adv2;
    assign s_axis_tready[c] = adv1 & !reset;
    assign acc           = s_axis_tvalid[c] & s_axis_tready[c];

    // The first beat of a packet picks up a pending shadow weight in the same cycle.
    assign first_apply   = acc & !in_pkt & pending;
    assign w_use         = (!in_pkt && pending) ? w_shd : w_act;

    // Stage 1 / stage 2 control
    always_ff @(posedge clock) begin
      if (reset) begin
        vld_p1  <= 1'b0;
        vld_p2  <= 1'b0;
        last_p1 <= 1'b0;
        last_p2 <= 1'b0;
        in_pkt  <= 1'b0;
      end else begin
        if (adv1) begin
          vld_p1  <= s_axis_tvalid[c];
          last_p1 <= s_axis_tvalid[c] & s_axis_tlast[c];
        end
        if (adv2) begin
          vld_p2  <= vld_p1;
          last_p2 <= last_p1;
        end
        if (acc) in_pkt <= !s_axis_tlast[c];
      end
    end

    // A capture coinciding with an apply wins, so the new shadow stays pending.
    always_ff @(posedge clock) begin
      if (reset) begin
        w_act   <= W_RESET;
        w_shd   <= W_RESET;
        pending <= 1'b0;
      end else begin
        if (first_apply) begin
          w_act   <= w_shd;
          pending <= 1'b0;
        end
        if (weight_update) begin
          w_shd.re <= weight_re[c*WEIGHT_WIDTH +: WEIGHT_WIDTH];
          w_shd.im <= weight_im[c*WEIGHT_WIDTH +: WEIGHT_WIDTH];
          pending  <= 1'b1;
        end
      end
    end

    assign m_axis_tvalid[c]  = vld_p2;
    assign m_axis_tlast[c]   = last_p2;
    assign weight_pending[c] = pending;

    for (genvar k = 0; k < SAMPLES; k++) begin : g_smp
      localparam int LSB = c * CH_W + samp_lsb(k);
      sample_t y_re, y_im;

      cmul_pipe u_cmul (
        .clock (clock),
        .adv1  (adv1),
        .adv2  (adv2),
        .a_re  (s_axis_tdata[LSB +: SAMPLE_WIDTH]),
        .a_im  (s_axis_tdata[LSB + SAMPLE_WIDTH +: SAMPLE_WIDTH]),
        .w_re  (w_use.re),
        .w_im  (w_use.im),
        .y_re  (y_re),
        .y_im  (y_im)
      );

      assign m_axis_tdata[LSB +: SAMPLE_WIDTH]                = vld_p2 ? y_re : '0;
      assign m_axis_tdata[LSB + SAMPLE_WIDTH +: SAMPLE_WIDTH] = vld_p2 ? y_im : '0;
    end
  end

endmodule

// File: tb/tb_axis_cweight_stage.sv
// Directed self-checking bench for axis_cweight_stage (both CWEIGHT_ROUND_SAT_EN builds).
module tb_axis_cweight_stage;

  localparam int NC = 4;
  localparam int NS = 8;
  localparam int SW = 8;
  localparam int WW = 16;
  localparam int DW = 2 * SW * NS;
  localparam int N  = 8;

`ifdef CWEIGHT_ROUND_SAT_EN
  localparam int U64  = 64;
  localparam int H3   = 2;
  localparam int NEG1 = 127;
`else
  localparam int U64  = 63;
  localparam int H3   = 1;
  localparam int NEG1 = -128;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic [NC*DW-1:0]  s_axis_tdata;
  logic [NC-1:0]     s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [NC*DW-1:0]  m_axis_tdata;
  logic [NC-1:0]     m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [NC*WW-1:0]  weight_re, weight_im;
  logic              weight_update;
  logic [NC-1:0]     weight_pending;

  int checks = 0;
  int errors = 0;

  axis_cweight_stage #(.NUM_CH(NC), .SAMPLES(NS)) dut (
    .clock          (clock),
    .reset          (reset),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tready  (s_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tready  (m_axis_tready),
    .weight_re      (weight_re),
    .weight_im      (weight_im),
    .weight_update  (weight_update),
    .weight_pending (weight_pending)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ch(input int c, input int re, input int im, input logic v, input logic l);
    for (int k = 0; k < NS; k++) begin
      s_axis_tdata[c*DW + k*2*SW +: SW]      = re[SW-1:0];
      s_axis_tdata[c*DW + k*2*SW + SW +: SW] = im[SW-1:0];
    end
    s_axis_tvalid[c] = v;
    s_axis_tlast[c]  = l;
  endtask

  function automatic logic signed [31:0] out_re(input int c, input int k);
    logic signed [SW-1:0] v;
    v = m_axis_tdata[c*DW + k*2*SW +: SW];
    return 32'(v);
  endfunction

  function automatic logic signed [31:0] out_im(input int c, input int k);
    logic signed [SW-1:0] v;
    v = m_axis_tdata[c*DW + k*2*SW + SW +: SW];
    return 32'(v);
  endfunction

  initial begin
    int tx2, tx3, rx2, rx3;
    logic stall_prev;
    logic signed [31:0] prev_im;

    reset         = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    m_axis_tready = '1;
    weight_re     = '0;
    weight_im     = '0;
    weight_update = 1'b0;
    tick();
    tick();

    chk("rst_mvalid",  32'(m_axis_tvalid), 0);
    chk("rst_mlast",   32'(m_axis_tlast), 0);
    chk("rst_mdata",   32'(|m_axis_tdata), 0);
    chk("rst_sready",  32'(s_axis_tready), 0);
    chk("rst_pending", 32'(weight_pending), 0);
    reset = 1'b0;
    #1;
    chk("sready_after_rst", 32'(s_axis_tready), 15);

    // reset weights on ch0, single-beat packet
    set_ch(0, 64, -32, 1'b1, 1'b1);
    tick();
    set_ch(0, 0, 0, 1'b0, 1'b0);
    chk("t1_lat1_valid", 32'(m_axis_tvalid[0]), 0);
    tick();
    chk("t1_valid", 32'(m_axis_tvalid[0]), 1);
    chk("t1_re0",   out_re(0, 0), U64);
    chk("t1_im0",   out_im(0, 0), -32);
    chk("t1_re7",   out_re(0, 7), U64);
    chk("t1_last",  32'(m_axis_tlast[0]), 1);
    tick();
    chk("t1_done",  32'(m_axis_tvalid[0]), 0);

    // mid-packet update on ch1 deferred to next packet
    set_ch(1, 64, -32, 1'b1, 1'b0);
    tick();
    weight_re     = {16'h4000, 16'h0000, 16'h4000, 16'h8000};
    weight_im     = {16'h0000, 16'h4000, 16'h0000, 16'h0000};
    weight_update = 1'b1;
    set_ch(1, 64, -32, 1'b1, 1'b1);
    tick();
    weight_update = 1'b0;
    chk("t2_pend_set", 32'(weight_pending), 15);
    chk("t2_b1_valid", 32'(m_axis_tvalid[1]), 1);
    chk("t2_b1_re",    out_re(1, 0), U64);
    chk("t2_b1_im",    out_im(1, 0), -32);
    chk("t2_b1_last",  32'(m_axis_tlast[1]), 0);
    set_ch(1, 3, -6, 1'b1, 1'b1);
    tick();
    set_ch(1, 0, 0, 1'b0, 1'b0);
    chk("t2_pend_clr", 32'(weight_pending), 13);
    chk("t2_b2_re",    out_re(1, 3), U64);
    chk("t2_b2_last",  32'(m_axis_tlast[1]), 1);
    tick();
    chk("t2_b3_re",    out_re(1, 0), H3);
    chk("t2_b3_im",    out_im(1, 7), -3);
    chk("t2_b3_last",  32'(m_axis_tlast[1]), 1);
    tick();
    chk("t2_done",     32'(m_axis_tvalid[1]), 0);

    // weight -1 on ch0 and j*0.5 on ch2
    set_ch(0, -128, -128, 1'b1, 1'b1);
    set_ch(2, 40, 20, 1'b1, 1'b1);
    tick();
    set_ch(0, 0, 0, 1'b0, 1'b0);
    set_ch(2, 0, 0, 1'b0, 1'b0);
    tick();
    chk("t3_neg_re", out_re(0, 2), NEG1);
    chk("t3_neg_im", out_im(0, 2), NEG1);
    chk("t4_j_re",   out_re(2, 5), -10);
    chk("t4_j_im",   out_im(2, 5), 20);
    chk("t4_pend",   32'(weight_pending), 8);
    tick();

    // backpressure on ch2 while ch3 streams at full rate
    tx2 = 0; tx3 = 0; rx2 = 0; rx3 = 0;
    stall_prev = 1'b0;
    prev_im    = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      m_axis_tready[2] = (cyc >= 5);
      if (tx2 < N) set_ch(2, 2*tx2 + 2, 0, 1'b1, tx2 == N-1);
      else         set_ch(2, 0, 0, 1'b0, 1'b0);
      if (tx3 < N) set_ch(3, 2*tx3 + 2, 0, 1'b1, tx3 == N-1);
      else         set_ch(3, 0, 0, 1'b0, 1'b0);
      #1;
      if (cyc == 2) begin
        chk("t5_sready_drop", 32'(s_axis_tready[2]), 0);
        chk("t5_tx_at_drop",  tx2, 2);
      end
      chk("t5_ch3_ready", 32'(s_axis_tready[3]), 1);
      if (stall_prev) begin
        chk("t5_hold_valid", 32'(m_axis_tvalid[2]), 1);
        chk("t5_hold_data",  out_im(2, 3), prev_im);
      end
      if (m_axis_tvalid[2] && m_axis_tready[2]) begin
        chk("t5_ch2_re",   out_re(2, 3), 0);
        chk("t5_ch2_im",   out_im(2, 3), rx2 + 1);
        chk("t5_ch2_last", 32'(m_axis_tlast[2]), (rx2 == N-1) ? 1 : 0);
        rx2++;
      end
      if (m_axis_tvalid[3]) begin
        chk("t5_ch3_re",   out_re(3, 3), rx3 + 1);
        chk("t5_ch3_im",   out_im(3, 3), 0);
        chk("t5_ch3_last", 32'(m_axis_tlast[3]), (rx3 == N-1) ? 1 : 0);
        rx3++;
      end
      stall_prev = m_axis_tvalid[2] & !m_axis_tready[2];
      prev_im    = out_im(2, 3);
      if (s_axis_tvalid[2] && s_axis_tready[2]) tx2++;
      if (s_axis_tvalid[3] && s_axis_tready[3]) tx3++;
      tick();
    end
    chk("t5_ch2_count", rx2, N);
    chk("t5_ch3_count", rx3, N);
    m_axis_tready = '1;

    // reset mid-packet with beats in flight on ch0 and ch1
    set_ch(0, 64, -32, 1'b1, 1'b0);
    set_ch(1, 64, -32, 1'b1, 1'b0);
    tick();
    tick();
    chk("t6_pre_valid", 32'(m_axis_tvalid[0]), 1);
    reset = 1'b1;
    set_ch(0, 0, 0, 1'b0, 1'b0);
    set_ch(1, 0, 0, 1'b0, 1'b0);
    tick();
    chk("t6_rst_valid",   32'(m_axis_tvalid), 0);
    chk("t6_rst_last",    32'(m_axis_tlast), 0);
    chk("t6_rst_data",    32'(|m_axis_tdata), 0);
    chk("t6_rst_sready",  32'(s_axis_tready), 0);
    chk("t6_rst_pending", 32'(weight_pending), 0);
    reset = 1'b0;
    weight_re     = {4{16'h4000}};
    weight_im     = '0;
    weight_update = 1'b1;
    set_ch(0, 64, -32, 1'b1, 1'b1);
    tick();
    weight_update = 1'b0;
    chk("t6_pend_coincide", 32'(weight_pending), 15);
    set_ch(0, 0, 0, 1'b0, 1'b0);
    set_ch(1, 3, -6, 1'b1, 1'b1);
    tick();
    set_ch(1, 0, 0, 1'b0, 1'b0);
    chk("t6_no_stale",  32'(m_axis_tvalid[1]), 0);
    chk("t6_a_valid",   32'(m_axis_tvalid[0]), 1);
    chk("t6_a_re",      out_re(0, 1), U64);
    chk("t6_a_im",      out_im(0, 1), -32);
    chk("t6_a_last",    32'(m_axis_tlast[0]), 1);
    tick();
    chk("t6_b_re",      out_re(1, 4), H3);
    chk("t6_b_im",      out_im(1, 4), -3);
    chk("t6_pend_after", 32'(weight_pending), 13);
    tick();
    chk("t6_idle", 32'(m_axis_tvalid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
